// File: rtl/dp_ram_sync_be.sv
// dp_ram_sync_be: true dual-port RAM with registered reads, per-byte write
// enables, selectable same-port read-during-write mode, port-A-priority
// cross-port write arbitration and a zero-fill sweep after reset.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   init_done             array ready; port requests ignored while 0
//   en_x / we_x           access request / write qualifier (x = a, b)
//   be_x                  byte enables, one bit per BYTE_WIDTH lane
//   addr_x / din_x        word address / write data
//   dout_x / dvalid_x     read data (held between reads) / one-cycle valid pulse
//   collision             one-cycle pulse for a same-address, overlapping-lane dual write
module dp_ram_sync_be #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned READ_MODE  = 0,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  output logic                             init_done,
  input  logic                             en_a,
  input  logic                             we_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  input  logic [DATA_WIDTH-1:0]            din_a,
  output logic [DATA_WIDTH-1:0]            dout_a,
  output logic                             dvalid_a,
  input  logic                             en_b,
  input  logic                             we_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [DATA_WIDTH-1:0]            din_b,
  output logic [DATA_WIDTH-1:0]            dout_b,
  output logic                             dvalid_b,
  output logic                             collision
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;

  localparam logic [1:0] S_RESET = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  sweep_we_c;

  logic                  init_done_q;
  logic                  acc_a_c, acc_b_c, wr_a_c, wr_b_c;
  logic [DATA_WIDTH-1:0] old_a_c, old_b_c, rd_a_c, rd_b_c;
  logic                  coll_c;

  logic [DATA_WIDTH-1:0] d1_a_q, d1_b_q;
  logic                  dv1_a_q, dv1_b_q;
  logic                  collision_q;

  // Lane-wise merge of write data over an existing word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [NB-1:0]         be
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_w[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sequencer next state: RESET -> (INIT sweep) -> READY.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sweep_we_c = 1'b0;
    case (state_q)
      S_RESET: begin
        cnt_d   = '0;
        state_d = (INIT_CLEAR != 0) ? S_INIT : S_READY;
      end
      S_INIT: begin
        sweep_we_c = 1'b1;
        cnt_d      = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_READY;
      end
      S_READY: begin
        state_d = S_READY;
      end
      default: begin
        state_d = S_RESET;
      end
    endcase
  end

  // Request qualification and read-data selection.
  always_comb begin
    acc_a_c = en_a & init_done_q;
    acc_b_c = en_b & init_done_q;
    wr_a_c  = acc_a_c & we_a;
    wr_b_c  = acc_b_c & we_b;
    old_a_c = mem[addr_a];
    old_b_c = mem[addr_b];
    // Write-first only merges the port's own write; the other port's write is never visible.
    rd_a_c  = ((READ_MODE != 0) && we_a) ? merge_lanes(old_a_c, din_a, be_a) : old_a_c;
    rd_b_c  = ((READ_MODE != 0) && we_b) ? merge_lanes(old_b_c, din_b, be_b) : old_b_c;
    coll_c  = wr_a_c & wr_b_c & (addr_a == addr_b) & (|(be_a & be_b));
  end

  // Array write: sweep, else port B then port A so A owns any shared lane.
  always_ff @(posedge clk) begin
    if (sweep_we_c) begin
      mem[cnt_q] <= '0;
    end else begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (wr_b_c && be_b[i]) mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        if (wr_a_c && be_a[i]) mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // First read stage, ready flag and collision pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_done_q <= 1'b0;
      d1_a_q      <= '0;
      d1_b_q      <= '0;
      dv1_a_q     <= 1'b0;
      dv1_b_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      init_done_q <= (state_d == S_READY);
      dv1_a_q     <= acc_a_c;
      dv1_b_q     <= acc_b_c;
      if (acc_a_c) d1_a_q <= rd_a_c;
      if (acc_b_c) d1_b_q <= rd_b_c;
      collision_q <= coll_c;
    end
  end

  assign init_done = init_done_q;
  assign collision = collision_q;

  // Optional output pipeline stage.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] d2_a_q, d2_b_q;
    logic                  dv2_a_q, dv2_b_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        d2_a_q  <= '0;
        d2_b_q  <= '0;
        dv2_a_q <= 1'b0;
        dv2_b_q <= 1'b0;
      end else begin
        dv2_a_q <= dv1_a_q;
        dv2_b_q <= dv1_b_q;
        if (dv1_a_q) d2_a_q <= d1_a_q;
        if (dv1_b_q) d2_b_q <= d1_b_q;
      end
    end

    assign dout_a   = d2_a_q;
    assign dout_b   = d2_b_q;
    assign dvalid_a = dv2_a_q;
    assign dvalid_b = dv2_b_q;
  end else begin : g_no_out_reg
    assign dout_a   = d1_a_q;
    assign dout_b   = d1_b_q;
    assign dvalid_a = dv1_a_q;
    assign dvalid_b = dv1_b_q;
  end

endmodule

// File: tb/tb_dp_ram_sync_be.sv
// Bench for dp_ram_sync_be: two instances (read-first/no output register and
// write-first/output register) share one stimulus stream and are compared
// against a word-array model with expected output registers per instance.
module tb_dp_ram_sync_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [5:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic        d0_init, d0_va, d0_vb, d0_coll;
  logic [31:0] d0_da, d0_db;
  logic        d1_init, d1_va, d1_vb, d1_coll;
  logic [31:0] d1_da, d1_db;

  always #5 clk = ~clk;

  dp_ram_sync_be #(.READ_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_done(d0_init),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(d0_da), .dvalid_a(d0_va),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(d0_db), .dvalid_b(d0_vb), .collision(d0_coll)
  );

  dp_ram_sync_be #(.READ_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_done(d1_init),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(d1_da), .dvalid_a(d1_va),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(d1_db), .dvalid_b(d1_vb), .collision(d1_coll)
  );

  // Reference model state.
  logic [31:0] m [64];
  bit          m_ready;
  int          rel_cnt;
  logic [31:0] e0_da, e0_db, s1_da, s1_db, e1_da, e1_db;
  bit          e0_va, e0_vb, s1_va, s1_vb, e1_va, e1_vb, e_coll;

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = 4'h0; addr_a = 6'h0; din_a = 32'h0;
    en_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = 6'h0; din_b = 32'h0;
  endtask

  task automatic port_a(input bit we, input logic [3:0] be, input logic [5:0] ad, input logic [31:0] d);
    en_a = 1'b1; we_a = we; be_a = be; addr_a = ad; din_a = d;
  endtask

  task automatic port_b(input bit we, input logic [3:0] be, input logic [5:0] ad, input logic [31:0] d);
    en_b = 1'b1; we_b = we; be_b = be; addr_b = ad; din_b = d;
  endtask

  // One clock: evaluate the model on the current inputs, advance, then check both DUTs.
  task automatic tick();
    logic [31:0] oa, ob, r1a, r1b;
    bit aa, ab, col, same_wa;
    aa  = en_a && m_ready;
    ab  = en_b && m_ready;
    oa  = m[addr_a];
    ob  = m[addr_b];
    r1a = we_a ? merge(oa, din_a, be_a) : oa;
    r1b = we_b ? merge(ob, din_b, be_b) : ob;
    col = aa && ab && we_a && we_b && (addr_a == addr_b) && ((be_a & be_b) != 4'h0);
    same_wa = aa && we_a && (addr_a == addr_b);
    @(posedge clk);
    if (!rst_n) begin
      m_ready = 0; rel_cnt = 0;
      e0_da = '0; e0_db = '0; s1_da = '0; s1_db = '0; e1_da = '0; e1_db = '0;
      e0_va = 0; e0_vb = 0; s1_va = 0; s1_vb = 0; e1_va = 0; e1_vb = 0; e_coll = 0;
    end else begin
      if (!m_ready) begin
        rel_cnt++;
        if (rel_cnt == 65) begin
          m_ready = 1;
          for (int i = 0; i < 64; i++) m[i] = '0;
        end
      end
      if (ab && we_b) m[addr_b] = merge(m[addr_b], din_b, be_b & ~(same_wa ? be_a : 4'h0));
      if (aa && we_a) m[addr_a] = merge(m[addr_a], din_a, be_a);
      e1_va = s1_va; e1_vb = s1_vb;
      if (s1_va) e1_da = s1_da;
      if (s1_vb) e1_db = s1_db;
      s1_va = aa; s1_vb = ab;
      if (aa) s1_da = r1a;
      if (ab) s1_db = r1b;
      e0_va = aa; e0_vb = ab;
      if (aa) e0_da = oa;
      if (ab) e0_db = ob;
      e_coll = col;
    end
    #1;
    chk("d0.init_done", 32'(d0_init), 32'(m_ready));
    chk("d0.dout_a",    d0_da,        e0_da);
    chk("d0.dout_b",    d0_db,        e0_db);
    chk("d0.dvalid_a",  32'(d0_va),   32'(e0_va));
    chk("d0.dvalid_b",  32'(d0_vb),   32'(e0_vb));
    chk("d0.collision", 32'(d0_coll), 32'(e_coll));
    chk("d1.init_done", 32'(d1_init), 32'(m_ready));
    chk("d1.dout_a",    d1_da,        e1_da);
    chk("d1.dout_b",    d1_db,        e1_db);
    chk("d1.dvalid_a",  32'(d1_va),   32'(e1_va));
    chk("d1.dvalid_b",  32'(d1_vb),   32'(e1_vb));
    chk("d1.collision", 32'(d1_coll), 32'(e_coll));
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m[i] = '0;
    m_ready = 0; rel_cnt = 0;
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_dout_a", d0_da, 32'h0);

    // First sweep, with port A requesting (and writing) throughout.
    rst_n = 1'b1;
    port_a(1'b1, 4'hF, 6'h00, 32'hDEADBEEF);
    repeat (64) tick();
    chk("init_low_at_64", 32'(d0_init), 32'h0);
    tick();
    chk("init_high_at_65", 32'(d0_init), 32'h1);
    idle();

    // Preload nonzero data, then re-run the sweep.
    port_a(1'b1, 4'hF, 6'h00, 32'hCAFE0000); tick();
    port_a(1'b1, 4'hF, 6'h1F, 32'hCAFE001F); tick();
    port_a(1'b1, 4'hF, 6'h3F, 32'hCAFE003F); tick();
    idle();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    repeat (65) tick();
    chk("sweep_init_done", 32'(d0_init), 32'h1);
    port_a(1'b0, 4'h0, 6'h00, 32'h0); port_b(1'b0, 4'h0, 6'h1F, 32'h0); tick();
    chk("sweep_rd_00", d0_da, 32'h0);
    chk("sweep_rd_1f", d0_db, 32'h0);
    idle(); port_a(1'b0, 4'h0, 6'h3F, 32'h0); tick();
    chk("sweep_rd_3f", d0_da, 32'h0);
    idle(); tick(); tick();

    // Basic latency.
    port_a(1'b1, 4'hF, 6'h01, 32'hAABBCCDD); port_b(1'b1, 4'hF, 6'h02, 32'h11223344); tick();
    port_a(1'b0, 4'h0, 6'h01, 32'h0); port_b(1'b0, 4'h0, 6'h02, 32'h0); tick();
    chk("lat0_dout_a", d0_da, 32'hAABBCCDD);
    chk("lat0_dout_b", d0_db, 32'h11223344);
    idle(); tick();
    chk("lat0_dvalid_drop", 32'(d0_va), 32'h0);
    chk("lat1_dout_a", d1_da, 32'hAABBCCDD);
    chk("lat1_dvalid_a", 32'(d1_va), 32'h1);
    tick();
    chk("lat1_dvalid_drop", 32'(d1_va), 32'h0);

    // Byte enables and read-during-write mode.
    port_a(1'b1, 4'hF, 6'h05, 32'h12345678); tick();
    port_a(1'b1, 4'b0101, 6'h05, 32'hFFFFFFFF); tick();
    chk("rdw_read_first", d0_da, 32'h12345678);
    idle(); tick();
    chk("rdw_write_first", d1_da, 32'h12FF56FF);
    port_a(1'b0, 4'h0, 6'h05, 32'h0); tick();
    chk("be_later_read", d0_da, 32'h12FF56FF);
    idle(); tick();

    // Collision on overlapping lanes.
    port_a(1'b1, 4'hF, 6'h04, 32'h0); tick();
    port_a(1'b1, 4'b0011, 6'h04, 32'hAAAAAAAA); port_b(1'b1, 4'b0110, 6'h04, 32'hBBBBBBBB); tick();
    chk("coll_pulse", 32'(d0_coll), 32'h1);
    idle(); tick();
    chk("coll_single", 32'(d0_coll), 32'h0);
    port_a(1'b0, 4'h0, 6'h04, 32'h0); tick();
    chk("coll_result", d0_da, 32'h00BBAAAA);
    idle(); tick();

    // Cross-port read while the other port writes.
    port_a(1'b1, 4'hF, 6'h03, 32'h11); tick();
    port_a(1'b0, 4'h0, 6'h03, 32'h0); port_b(1'b1, 4'hF, 6'h03, 32'h22); tick();
    chk("xport_old", d0_da, 32'h11);
    chk("xport_nocoll", 32'(d0_coll), 32'h0);
    idle(); tick();
    chk("xport_old_wf", d1_da, 32'h11);
    port_a(1'b0, 4'h0, 6'h03, 32'h0); tick();
    chk("xport_new", d0_da, 32'h22);
    idle(); tick();

    // Random traffic on a small address window to provoke conflicts.
    for (int k = 0; k < 400; k++) begin
      en_a = 1'($urandom); we_a = 1'($urandom); be_a = 4'($urandom);
      addr_a = 6'($urandom_range(0, 7)); din_a = $urandom;
      en_b = 1'($urandom); we_b = 1'($urandom); be_b = 4'($urandom);
      addr_b = 6'($urandom_range(0, 7)); din_b = $urandom;
      tick();
    end
    idle(); tick(); tick();

    // Reset in the middle of a sweep, with requests held active.
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    port_a(1'b1, 4'hF, 6'h14, 32'h5A5A5A5A);
    repeat (21) tick();
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    for (int k = 0; k < 65; k++) begin
      we_a = 1'($urandom); addr_a = 6'($urandom); din_a = $urandom;
      tick();
    end
    chk("midsweep_init_done", 32'(d0_init), 32'h1);
    idle();
    port_a(1'b0, 4'h0, 6'h14, 32'h0); port_b(1'b0, 4'h0, 6'h3F, 32'h0); tick();
    chk("midsweep_rd_14", d0_da, 32'h0);
    idle(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
